// File: rtl/spi_tft_bus_arbiter_pkg.sv
// Shared definitions for the SPI TFT bus arbiter: FSM states, arbitration
// mode encodings and the per-requester byte width.
package spi_tft_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/spi_tft_rr_pick.sv
// Combinational winner picker. In fixed mode the lowest set request wins;
// in round-robin mode the search starts at ptr_i and wraps.
module spi_tft_rr_pick
  import spi_tft_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic               mode_i,
  output logic [NUM_REQ-1:0] win_onehot_o,
  output logic [IDX_W-1:0]   win_idx_o,
  output logic               win_valid_o
);

  // Scan candidates in priority order and keep the first one requesting.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand         = '0;
    win_onehot_o = '0;
    win_idx_o    = '0;
    win_valid_o  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (mode_i == ARB_RR) begin
        cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      end else begin
        cand = IDX_W'(k);
      end
      if (!win_valid_o && req_i[cand]) begin
        win_valid_o        = 1'b1;
        win_onehot_o[cand] = 1'b1;
        win_idx_o          = cand;
      end
    end
  end

endmodule

// File: rtl/spi_tft_bus_arbiter.sv
// Shares one SPI master byte engine between several transaction sources.
// The bus is owned for a whole CS-framed transaction (first request until
// the owner's end pulse), followed by a forced idle gap.
//
// Handshake: req_i is a level held by the requester until it sees its bit
// of grant_o; only the owner's req/end/data/dc reach the master, and the
// master's byte-done pulse is returned solely on ack_o[owner].
module spi_tft_bus_arbiter
  import spi_tft_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ARB_MODE   = 0,
  parameter int GAP_CYCLES = 4
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        end_i,
  input  logic [BYTE_W*NUM_REQ-1:0] data_i,
  input  logic [NUM_REQ-1:0]        dc_i,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic                      spi_start_o,
  output logic                      spi_end_o,
  output logic [BYTE_W-1:0]         spi_send_data_o,
  output logic                      lcd_dc_o,
  input  logic                      spi_send_ack_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o
);

  localparam int         IDX_W    = $clog2(NUM_REQ);
  localparam logic       MODE     = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  arb_state_e         state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   ptr_d;
  logic [7:0]         gap_q;
  logic               busy_q;

  logic [NUM_REQ-1:0] win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic               win_valid;

  spi_tft_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i        (req_i),
    .ptr_i        (ptr_q),
    .mode_i       (MODE),
    .win_onehot_o (win_onehot),
    .win_idx_o    (win_idx),
    .win_valid_o  (win_valid)
  );

  // Round-robin pointer moves to the slot just after the new winner.
  always_comb begin
    ptr_d = ptr_q;
    if (win_idx == IDX_W'(NUM_REQ - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = win_idx + 1'b1;
    end
  end

  // Owner mux: grant_q is zero outside GRANT, so every output falls to 0
  // in IDLE and GAP without extra state gating.
  always_comb begin
    spi_start_o     = |(req_i & grant_q);
    spi_end_o       = |(end_i & grant_q);
    lcd_dc_o        = |(dc_i & grant_q);
    ack_o           = grant_q & {NUM_REQ{spi_send_ack_i}};
    spi_send_data_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        spi_send_data_o = spi_send_data_o | data_i[k*BYTE_W +: BYTE_W];
      end
    end
  end

  // Arbitration FSM with gap counter; grant and busy are registered.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      gap_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_valid) begin
            state_q <= ST_GRANT;
            grant_q <= win_onehot;
            busy_q  <= 1'b1;
            if (MODE == ARB_RR) begin
              ptr_q <= ptr_d;
            end
          end
        end
        ST_GRANT: begin
          if (|(end_i & grant_q)) begin
            state_q <= ST_GAP;
            grant_q <= '0;
            gap_q   <= GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (gap_q == 8'd0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_spi_tft_bus_arbiter.sv
// Bench for spi_tft_bus_arbiter: a fixed-priority and a round-robin instance
// share the same stimulus and are each compared every cycle against a
// transaction-level reference model, plus directed checks per scenario.
module tb_spi_tft_bus_arbiter;

  localparam int N   = 3;
  localparam int GAP = 4;

  // ---------------- clock / reset / stimulus signals ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, endp, dc;
  logic [23:0] data;
  logic        ack;

  logic [2:0] ack_fx, grant_fx, ack_rr, grant_rr;
  logic       start_fx, endo_fx, dc_fx, busy_fx;
  logic       start_rr, endo_rr, dc_rr, busy_rr;
  logic [7:0] data_fx, data_rr;

  always #5 clk = ~clk;

  spi_tft_bus_arbiter #(.NUM_REQ(N), .ARB_MODE(0), .GAP_CYCLES(GAP)) dut_fx (
    .sys_clk(clk), .sys_rst(rst), .req_i(req), .end_i(endp), .data_i(data),
    .dc_i(dc), .ack_o(ack_fx), .spi_start_o(start_fx), .spi_end_o(endo_fx),
    .spi_send_data_o(data_fx), .lcd_dc_o(dc_fx), .spi_send_ack_i(ack),
    .grant_o(grant_fx), .busy_o(busy_fx)
  );

  spi_tft_bus_arbiter #(.NUM_REQ(N), .ARB_MODE(1), .GAP_CYCLES(GAP)) dut_rr (
    .sys_clk(clk), .sys_rst(rst), .req_i(req), .end_i(endp), .data_i(data),
    .dc_i(dc), .ack_o(ack_rr), .spi_start_o(start_rr), .spi_end_o(endo_rr),
    .spi_send_data_o(data_rr), .lcd_dc_o(dc_rr), .spi_send_ack_i(ack),
    .grant_o(grant_rr), .busy_o(busy_rr)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  // Reference model, index 0 = fixed instance, 1 = round-robin instance.
  // owner = -1 means nobody holds the bus; gap_left counts idle cycles owed.
  int owner[2];
  int gap_left[2];
  int ptr[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [2:0] r, input int rr, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = rr ? (p + k) % N : k;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // Sample on the falling edge and compare both instances to the model.
  task automatic settle();
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      logic [2:0] eg, ea, og, oa;
      logic       es, ee, edc, eb, os, oe, odc, ob;
      logic [7:0] ed, od;
      string      nm;
      nm  = (m == 0) ? "fx" : "rr";
      eg  = 3'b000; ea = 3'b000; es = 1'b0; ee = 1'b0; edc = 1'b0; ed = 8'h00;
      if (owner[m] >= 0) begin
        eg  = 3'(1 << owner[m]);
        ea  = ack ? eg : 3'b000;
        es  = req[owner[m]];
        ee  = endp[owner[m]];
        edc = dc[owner[m]];
        ed  = data[8*owner[m] +: 8];
      end
      eb  = (owner[m] >= 0) || (gap_left[m] > 0);
      og  = (m == 0) ? grant_fx : grant_rr;
      oa  = (m == 0) ? ack_fx   : ack_rr;
      os  = (m == 0) ? start_fx : start_rr;
      oe  = (m == 0) ? endo_fx  : endo_rr;
      odc = (m == 0) ? dc_fx    : dc_rr;
      ob  = (m == 0) ? busy_fx  : busy_rr;
      od  = (m == 0) ? data_fx  : data_rr;
      chk($sformatf("%s_grant", nm), og, eg);
      chk($sformatf("%s_busy", nm), ob, eb);
      chk($sformatf("%s_start", nm), os, es);
      chk($sformatf("%s_end", nm), oe, ee);
      chk($sformatf("%s_data", nm), od, ed);
      chk($sformatf("%s_dc", nm), odc, edc);
      chk($sformatf("%s_ack", nm), oa, ea);
    end
  endtask

  // Advance the model across the rising edge, then move past it; end and
  // ack are one-cycle pulses so they drop automatically.
  task automatic adv();
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        owner[m] = -1; gap_left[m] = 0; ptr[m] = 0;
      end else if (owner[m] >= 0) begin
        if (endp[owner[m]]) begin
          owner[m] = -1; gap_left[m] = GAP;
        end
      end else if (gap_left[m] > 0) begin
        gap_left[m]--;
      end else if (req != 3'b000) begin
        owner[m] = pick(req, m, ptr[m]);
        if (m == 1) ptr[m] = (owner[m] + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    endp = 3'b000;
    ack  = 1'b0;
  endtask

  task automatic step();
    settle();
    adv();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] bytes[3];
    logic [2:0] rr_order[4];
    int zeros;
    bytes    = '{8'h2A, 8'h00, 8'h3F};
    rr_order = '{3'b001, 3'b010, 3'b100, 3'b001};
    rst = 1'b1; req = '0; endp = '0; dc = '0; data = '0; ack = 1'b0;
    for (int m = 0; m < 2; m++) begin
      owner[m] = -1; gap_left[m] = 0; ptr[m] = 0;
    end
    adv();
    adv();
    rst = 1'b0;

    // Reset state
    settle();
    chk("rst_grant", grant_fx, 3'b000);
    chk("rst_busy", busy_rr, 1'b0);
    adv();

    // 1: single requester, three acked bytes, end, gap
    req = 3'b010;
    dc  = 3'b010;
    step();
    settle();
    chk("t1_grant", grant_fx, 3'b010);
    adv();
    for (int b = 0; b < 3; b++) begin
      data[15:8] = bytes[b];
      ack = 1'b1;
      settle();
      chk("t1_ack", ack_fx, 3'b010);
      chk("t1_byte", data_fx, bytes[b]);
      adv();
      step();
    end
    endp = 3'b010;
    settle();
    chk("t1_end", endo_fx, 1'b1);
    adv();
    req = 3'b000;
    for (int i = 0; i < GAP; i++) begin
      settle();
      chk("t1_gap_busy", busy_fx, 1'b1);
      adv();
    end
    settle();
    chk("t1_idle_busy", busy_fx, 1'b0);
    adv();

    // 2: fixed priority, held request wins again, dropped request yields
    req = 3'b110;
    step();
    settle();
    chk("t2_grant", grant_fx, 3'b010);
    adv();
    endp = 3'b111;
    step();
    repeat (GAP + 1) step();
    settle();
    chk("t2_regrant", grant_fx, 3'b010);
    adv();
    endp = 3'b111;
    req  = 3'b100;
    step();
    repeat (GAP + 1) step();
    settle();
    chk("t2_next", grant_fx, 3'b100);
    adv();
    endp = 3'b111;
    req  = 3'b000;
    step();
    repeat (GAP + 2) step();

    // 3: round-robin rotation with all requests held
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 3'b111;
    step();
    settle();
    for (int t = 0; t < 4; t++) begin
      chk("t3_rr_order", grant_rr, rr_order[t]);
      adv();
      ack = 1'b1;
      step();
      endp = 3'b111;
      step();
      if (t < 3) begin
        zeros = 0;
        settle();
        while (grant_rr == 3'b000 && zeros < 20) begin
          zeros++;
          adv();
          settle();
        end
        chk("t3_rr_gap", zeros, GAP + 1);
      end
    end
    req = 3'b000;
    repeat (GAP + 2) step();

    // 4: isolation of a non-owner's end/data/ack
    req = 3'b001;
    step();
    for (int i = 0; i < 8; i++) begin
      data[23:16] = 8'hFF;
      data[7:0]   = 8'($urandom);
      endp        = (i % 2 == 0) ? 3'b100 : 3'b000;
      ack         = i[0];
      settle();
      chk("t4_end", endo_fx, 1'b0);
      chk("t4_ack2", ack_fx[2], 1'b0);
      chk("t4_data", data_fx, data[7:0]);
      adv();
    end

    // 5: owner drops its request without ending
    req = 3'b110;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("t5_grant", grant_fx, 3'b001);
      chk("t5_start", start_fx, 1'b0);
      adv();
    end
    req  = 3'b001;
    endp = 3'b001;
    step();
    req = 3'b000;
    repeat (GAP + 2) step();

    // 6: reset mid-transaction clears state and the RR pointer
    req = 3'b111;
    step();
    ack = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    chk("t6_grant", grant_rr, 3'b000);
    chk("t6_busy", busy_rr, 1'b0);
    chk("t6_start", start_fx, 1'b0);
    adv();
    settle();
    chk("t6_rr_ptr", grant_rr, 3'b001);
    adv();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      req  = 3'($urandom_range(0, 7));
      endp = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      data = 24'($urandom);
      dc   = 3'($urandom_range(0, 7));
      ack  = 1'($urandom_range(0, 1));
      rst  = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_tft_bus_arbiter.md
Name: spi_tft_bus_arbiter

Overview:
Shares the single SPI master byte engine between several transaction sources, e.g. panel init, full-frame flush and partial-window/command injector. Grants the bus at transaction granularity, from a requester's first request until its end pulse, so a CS-framed transaction is never interleaved. Enforces a minimum CS-idle gap between transactions. Sits between the screen-level sequencers and the SPI master driver, replacing the hard-wired init/flush mux.

Parameters:
NUM_REQ, 3, number of requesters (2..4); index 0 = init source.
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
GAP_CYCLES, 4, sys_clk cycles of forced idle after each end before re-arbitration (1..255).

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous reset, active-high
req_i  in  NUM_REQ  per-requester level "start/keep transaction" (maps to spi_start)
end_i  in  NUM_REQ  per-requester single-cycle end-of-transaction pulse
data_i  in  8*NUM_REQ  per-requester byte; slice k = bits [8k+7:8k]
dc_i  in  NUM_REQ  per-requester data/command flag
ack_o  out  NUM_REQ  byte-sent ack, routed to grant owner only
spi_start_o  out  1  to master start input
spi_end_o  out  1  to master end input
spi_send_data_o  out  8  to master data input
lcd_dc_o  out  1  to master dc input
spi_send_ack_i  in  1  master 8-bit-done pulse
grant_o  out  NUM_REQ  one-hot current owner, 0 when idle/gap
busy_o  out  1  high in GRANT or GAP

Behaviour:
- Reset: state IDLE; grant_o=0; busy_o=0; RR pointer=0; gap counter=0; all master-side outputs 0; ack_o=0. Reset mid-transaction aborts immediately. No end is forwarded; the master's own reset closes CS.
- States: IDLE, GRANT, GAP.
- IDLE: if any req_i is high, choose a winner and register it. Next cycle: state=GRANT, grant_o=onehot(winner), busy_o=1. Arbitration latency is 1 cycle.
- Fixed mode: lowest set index wins.
- RR mode: first set index at or after the pointer (wrapping). On grant, pointer <= winner+1 mod NUM_REQ.
- GRANT: master-side outputs are combinational muxes of the owner's req/end/data/dc. ack_o[owner]=spi_send_ack_i; other ack bits are 0. Inputs from non-owners are ignored, including their end_i.
- Owner deasserting req_i without end_i does not release the grant. Only end_i[owner] releases it.
- end_i[owner]=1: forwarded on spi_end_o in the same cycle. Next state is GAP; gap counter is loaded with GAP_CYCLES-1.
- Same-cycle ack and end: the ack is still routed to the owner in that cycle.
- GAP: all master-side outputs 0, grant_o=0, busy_o=1. Counter decrements; at 0 the next state is IDLE. Minimum gap is GAP_CYCLES cycles, plus 1 arbitration cycle before the next spi_start_o.
- Requests arriving during GRANT or GAP are held by the requester (level) and arbitrated in IDLE. No request queueing inside the block.
- Same requester re-requesting after end: in RR mode it gets lowest priority if others are pending. In fixed mode it wins again if it is the lowest index.
- spi_send_ack_i outside GRANT is dropped; ack_o stays 0.
- Invariants: grant_o is always one-hot or zero. spi_start_o is never high outside GRANT.

Decomposition:
- Shared package: state encoding (ST_IDLE, ST_GRANT, ST_GAP), ARB_FIXED/ARB_RR constants, and the byte-slice width constant.
- One natural sub-module, spi_tft_rr_pick: pure combinational priority/round-robin picker. Inputs are the req vector, pointer and mode; outputs are a one-hot winner and its index.
- Muxing, FSM and gap counter live in the top.

Test Plan:
1. Single requester: req_i=3'b010, 3 bytes (0x2A, 0x00, 0x3F) acked, then end_i[1]. Expect grant_o=010 one cycle after req, three ack_o[1] pulses, spi_end_o same cycle as end_i[1], then busy_o high for 4 more cycles.
2. Fixed priority: req_i=3'b110 in IDLE. Expect grant_o=010. After end and gap, expect grant_o=100 only if req[1] has dropped; if req[1] is still held, expect 010 again.
3. Round-robin: ARB_MODE=1, req_i=3'b111 held continuously. Expect grant order 001, 010, 100, 001, each separated by ≥5 cycles of spi_start_o low.
4. Isolation: owner 0 streaming while requester 2 toggles end_i[2] and data_i slice 2=0xFF. Expect spi_end_o, spi_send_data_o and ack_o[2] unaffected; ack_o[2] stays 0.
5. Owner drops req_i for 10 cycles without end. Expect grant_o unchanged, spi_start_o=0 during the drop, and no other requester granted.
6. sys_rst asserted mid-GRANT after 1 byte. Expect all outputs 0 on the next edge, state IDLE, and RR pointer 0: with req_i=3'b111 after reset, grant_o=001.
